// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARMv4-subset controller.
// Holds the FSM state enum, datapath mux encodings and the condition check.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // flags is {N,Z,C,V}; code 1111 falls to the default and never executes
    function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v, res;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~(c & ~z);
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = ~(~z & (n == v));
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in, write
// enables and mux selects out. master = controller, slave = datapath.
interface mc_if;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite;
    logic         IRWrite;
    logic         RegWrite;
    logic         MemWrite;
    logic         AdrSrc;
    logic         ALUSrcA;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ResultSrc;
    logic [1:0]   ImmSrc;
    logic [1:0]   RegSrc;
    logic [1:0]   ALUControl;
    logic [3:0]   State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
    );
endinterface

// File: rtl/mc_condunit.sv
// NZCV flag register with split N/Z and C/V enables, plus the per-instruction
// registered condition result.
module mc_condunit
    import mc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_nz_we,
    input  logic       i_cv_we,
    input  logic       i_cond_en,
    output logic       o_cond_q
);

    logic [3:0] r_flags;
    logic       r_cond_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags  <= 4'b0000;
            r_cond_q <= 1'b0;
        end else begin
            if (i_nz_we) r_flags[3:2] <= i_alu_flags[3:2];
            if (i_cv_we) r_flags[1:0] <= i_alu_flags[1:0];
            // cond is evaluated against flags as they stand entering DECODE
            if (i_cond_en) r_cond_q <= condcheck(i_cond, r_flags);
        end
    end

    assign o_cond_q = r_cond_q;

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the ARMv4-subset core: sequences fetch/decode/
// execute/writeback and decodes the ALU operation; flags live in mc_condunit.
module mc_controller
    import mc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);

    state_t     r_state;
    state_t     w_next;

    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic [3:0] w_cond;
    logic       w_rd_pc;
    logic       w_cond_q;
    logic [1:0] w_dp_alu;
    logic       w_is_exec;
    logic       w_nz_we;
    logic       w_cv_we;
    logic       w_unused_rn;

    logic       w_pc_write, w_ir_write, w_reg_write, w_mem_write;
    logic       w_adr_src, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_result_src, w_imm_src, w_alu_control;

    assign w_cond      = bus.Instr[31:28];
    assign w_op        = bus.Instr[27:26];
    assign w_funct     = bus.Instr[25:20];
    assign w_rd        = bus.Instr[15:12];
    assign w_rd_pc     = (w_rd == 4'hF);
    assign w_unused_rn = ^bus.Instr[19:16];

    always_comb begin
        unique case (w_funct[4:1])
            4'b0100: w_dp_alu = ALU_ADD;
            4'b0010: w_dp_alu = ALU_SUB;
            4'b0000: w_dp_alu = ALU_AND;
            4'b1100: w_dp_alu = ALU_ORR;
            default: w_dp_alu = ALU_ADD;
        endcase
    end

    assign w_is_exec = (r_state == S_EXECR) || (r_state == S_EXECI);
    assign w_nz_we   = w_is_exec & w_funct[0] & w_cond_q;
    // C/V are only meaningful for the arithmetic ops
    assign w_cv_we   = w_nz_we & ((w_dp_alu == ALU_ADD) || (w_dp_alu == ALU_SUB));

    mc_condunit u_condunit (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_cond      (w_cond),
        .i_alu_flags (bus.ALUFlags),
        .i_nz_we     (w_nz_we),
        .i_cv_we     (w_cv_we),
        .i_cond_en   (r_state == S_DECODE),
        .o_cond_q    (w_cond_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        unique case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                unique case (w_op)
                    2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_write   = 1'b0;
        w_adr_src     = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = SRCB_REG;
        w_result_src  = RES_ALUOUT;
        w_imm_src     = IMM_DP;
        w_alu_control = ALU_ADD;
        unique case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_write   = 1'b1;
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
            end
            S_MEMADR: begin
                w_alu_src_b = SRCB_IMM;
                w_imm_src   = IMM_MEM;
            end
            S_MEMRD:  w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = w_cond_q;
                w_pc_write   = w_cond_q & w_rd_pc;
            end
            S_MEMWR: begin
                w_adr_src   = 1'b1;
                w_mem_write = w_cond_q;
            end
            S_EXECR:  w_alu_control = w_dp_alu;
            S_EXECI: begin
                w_alu_src_b   = SRCB_IMM;
                w_alu_control = w_dp_alu;
            end
            S_ALUWB: begin
                w_reg_write = w_cond_q;
                w_pc_write  = w_cond_q & w_rd_pc;
            end
            S_BRANCH: begin
                w_alu_src_b  = SRCB_IMM;
                w_imm_src    = IMM_BR;
                w_result_src = RES_ALURESULT;
                w_pc_write   = w_cond_q;
            end
            default: ;
        endcase
    end

    // reset is async, so enables must be squashed combinationally while it is high
    assign bus.PCWrite    = w_pc_write  & ~reset;
    assign bus.IRWrite    = w_ir_write  & ~reset;
    assign bus.RegWrite   = w_reg_write & ~reset;
    assign bus.MemWrite   = w_mem_write & ~reset;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.ALUControl = w_alu_control;
    assign bus.RegSrc     = {(w_op == 2'b01) & ~w_funct[0], (w_op == 2'b10)};
    assign bus.State      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: steps instructions through the FSM and
// checks state, enables and selects at each negative clock edge.
module tb_mc_controller;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    mc_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic ld(input logic [31:0] w);
        bus.Instr = w[31:12];
    endtask

    task automatic st(input string tag, input state_t exp);
        chk(tag, 32'(bus.State), 32'(exp));
    endtask

    // B-class instruction from FETCH: DECODE, BRANCH, back to FETCH
    task automatic branch(input string tag, input logic [31:0] w, input logic exp_pcw);
        ld(w);
        cyc();
        cyc();
        st({tag, "_state"}, S_BRANCH);
        chk({tag, "_pcw"}, 32'(bus.PCWrite), 32'(exp_pcw));
        cyc();
        st({tag, "_back"}, S_FETCH);
    endtask

    initial begin
        reset        = 1'b1;
        bus.ALUFlags = 4'b0000;
        ld(32'hE2802005);
        cyc();
        st("rst_state", S_FETCH);
        chk("rst_pcw", 32'(bus.PCWrite), 32'd0);
        chk("rst_irw", 32'(bus.IRWrite), 32'd0);
        chk("rst_srcb", 32'(bus.ALUSrcB), 32'd2);
        chk("rst_srca", 32'(bus.ALUSrcA), 32'd1);
        chk("rst_res", 32'(bus.ResultSrc), 32'd2);
        reset = 1'b0;
        #1;
        chk("fetch_irw", 32'(bus.IRWrite), 32'd1);
        chk("fetch_pcw", 32'(bus.PCWrite), 32'd1);

        // ADD R2,R0,#5
        cyc();  st("add_dec", S_DECODE);
        chk("add_dec_regw", 32'(bus.RegWrite), 32'd0);
        cyc();  st("add_execi", S_EXECI);
        chk("add_srcb", 32'(bus.ALUSrcB), 32'd1);
        chk("add_aluctl", 32'(bus.ALUControl), 32'd0);
        chk("add_execi_regw", 32'(bus.RegWrite), 32'd0);
        cyc();  st("add_aluwb", S_ALUWB);
        chk("add_wb_regw", 32'(bus.RegWrite), 32'd1);
        chk("add_wb_pcw", 32'(bus.PCWrite), 32'd0);
        cyc();  st("add_done", S_FETCH);

        // STR R1,[R0,#100]
        ld(32'hE5801064);
        cyc();  chk("str_regsrc", 32'(bus.RegSrc), 32'd2);
        cyc();  st("str_memadr", S_MEMADR);
        chk("str_immsrc", 32'(bus.ImmSrc), 32'd1);
        chk("str_adr_memw", 32'(bus.MemWrite), 32'd0);
        cyc();  st("str_memwr", S_MEMWR);
        chk("str_memw", 32'(bus.MemWrite), 32'd1);
        chk("str_adrsrc", 32'(bus.AdrSrc), 32'd1);
        chk("str_regw", 32'(bus.RegWrite), 32'd0);
        cyc();  st("str_done", S_FETCH);

        // LDR R2,[R0,#96]
        ld(32'hE5902060);
        cyc();  cyc();
        cyc();  st("ldr_memrd", S_MEMRD);
        chk("ldr_adrsrc", 32'(bus.AdrSrc), 32'd1);
        cyc();  st("ldr_memwb", S_MEMWB);
        chk("ldr_res", 32'(bus.ResultSrc), 32'd1);
        chk("ldr_regw", 32'(bus.RegWrite), 32'd1);
        chk("ldr_pcw", 32'(bus.PCWrite), 32'd0);
        cyc();  st("ldr_done", S_FETCH);

        // LDR PC,[R0,#96]
        ld(32'hE590F060);
        cyc();  cyc();  cyc();
        cyc();  chk("ldrpc_pcw", 32'(bus.PCWrite), 32'd1);
        cyc();  st("ldrpc_done", S_FETCH);

        // SUBS R3,R3,R4 with ALU reporting Z
        ld(32'hE0530004);
        cyc();
        cyc();  st("subs_execr", S_EXECR);
        chk("subs_aluctl", 32'(bus.ALUControl), 32'd1);
        chk("subs_srcb", 32'(bus.ALUSrcB), 32'd0);
        bus.ALUFlags = 4'b0100;
        cyc();  bus.ALUFlags = 4'b0000;
        chk("subs_regw", 32'(bus.RegWrite), 32'd1);
        cyc();

        branch("beq_taken", 32'h0A000002, 1'b1);
        branch("bne_not", 32'h1A000002, 1'b0);

        // ORRS: N,Z from ALU (1,0); C,V stay 0 despite ALU C=V=1
        ld(32'hE1913004);
        cyc();
        cyc();  chk("orrs_aluctl", 32'(bus.ALUControl), 32'd3);
        bus.ALUFlags = 4'b1011;
        cyc();  bus.ALUFlags = 4'b0000;
        cyc();

        branch("bmi_taken", 32'h4A000002, 1'b1);
        branch("bcs_not", 32'h2A000002, 1'b0);
        branch("bvs_not", 32'h6A000002, 1'b0);
        branch("beq_after_orrs", 32'h0A000002, 1'b0);

        // condition 1111 never executes
        ld(32'hF2802005);
        cyc();  cyc();
        cyc();  st("nv_aluwb", S_ALUWB);
        chk("nv_regw", 32'(bus.RegWrite), 32'd0);
        cyc();

        // undefined op: DECODE then straight back to FETCH, no writes
        ld(32'hEC000000);
        cyc();  st("undef_dec", S_DECODE);
        chk("undef_we", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}), 32'd0);
        cyc();  st("undef_done", S_FETCH);

        // reset in the middle of a store
        ld(32'hE5801064);
        cyc();  cyc();
        cyc();  chk("rstmid_memw_before", 32'(bus.MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_memw", 32'(bus.MemWrite), 32'd0);
        st("rstmid_state", S_FETCH);
        chk("rstmid_irw", 32'(bus.IRWrite), 32'd0);
        cyc();
        reset = 1'b0;
        branch("beq_after_rst", 32'h0A000002, 1'b0);
        branch("bpl_after_rst", 32'h5A000002, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARMv4-subset core: it sequences the shared datapath (one ALU, one unified memory port, instruction/data registers) through the fetch/decode/execute/writeback steps for ADD/SUB/AND/ORR, LDR/STR and B. It holds the NZCV flag register and registers the condition result once per instruction. It replaces the single-cycle controller/condlogic pair in the multicycle top level.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; state returns to FETCH and flags clear immediately.
- Instr  in  [31:12]  instruction register contents (cond, op, funct, rn, rd).
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  datapath write enables.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- ALUSrcA  out  1  0 = register A, 1 = PC.
- ALUSrcB  out  2  00 = register WriteData, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut register, 01 = Data register, 10 = ALUResult.
- ImmSrc, RegSrc, ALUControl  out  2 each  same encodings as the single-cycle core (ALUControl 00 ADD, 01 SUB, 10 AND, 11 ORR).
- State  out  4  current FSM state, for debug and bench checking.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional). Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD (PC+8 for R15 reads), ResultSrc=10. cond_q <= condcheck(Instr[31:28], Flags).
  - Op=01 goes to MEMADR.
  - Op=00 with Funct[5]=1 goes to EXECI; with Funct[5]=0 goes to EXECR.
  - Op=10 goes to BRANCH.
  - Op=11 goes to FETCH with no writes.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ADD. Funct[0]=1 goes to MEMRD, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=cond_q, PCWrite=cond_q&(Rd==15). Next state is FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=cond_q. Next state is FETCH.
- EXECR / EXECI:
  - ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI, ImmSrc=00).
  - ALUControl decoded from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, anything else ADD.
  - Flag update when S=1 and cond_q: N,Z always written; C,V written only for ADD/SUB.
  - Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=cond_q, PCWrite=cond_q&(Rd==15). Next state is FETCH.
- BRANCH: ALUSrcA=0 (RegSrc[0]=1 selects R15), ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=cond_q. Next state is FETCH.
- RegSrc: {Op==01 & ~Funct[0], Op==10}, held for the whole instruction.
- Every output not listed for a state is 0.
- Condition codes 0000–1110 decode as in the single-cycle core. Code 1111 evaluates false.

## Timing
- Reset:
  - State=FETCH, Flags=0000, cond_q=0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 while reset is high.
  - Mux selects show FETCH values while reset is high.
- The first rising edge after reset deasserts performs a fetch.
- Cycles per instruction: B=3, STR=4, DP=4, LDR=5, undefined=2.
- Controls are Moore outputs of the state plus the registered Instr and cond_q. The only path from ALUFlags is into the flag register; no output depends combinationally on ALUFlags.
- cond_q is sampled only at the end of DECODE. Flags written in EXEC therefore cannot alter the current instruction's gating.
- Asserting reset mid-instruction abandons the instruction: no further writes, and flags clear.

## Structure
- Shared package mc_pkg: state enum (4-bit), ALUControl/ResultSrc/ALUSrcB localparams, condition-code constants.
- One sub-module, mc_condunit, contains:
  - the flag register, with N/Z and C/V write enables split;
  - condcheck logic;
  - the cond_q register.
- The FSM and the ALU decode stay in mc_controller.

## Test plan
- Reset release with Instr=E2802005 (ADD R2,R0,#5): sequence FETCH, DECODE, EXECI, ALUWB, FETCH. RegWrite=1 only in ALUWB, with ALUSrcB=01 and ALUControl=00 in EXECI.
- E5801064 (STR R1,[R0,#100]): MemWrite=1 only in the 4th cycle, AdrSrc=1 there; RegWrite never asserted.
- E5902060 (LDR R2,[R0,#96]): 5-cycle sequence; MEMWB has ResultSrc=01 and RegWrite=1. The same instruction with Rd=15 also asserts PCWrite in MEMWB.
- Flags:
  - E0530004 (SUBS) with ALUFlags=0100 in EXECR: Flags become 0100.
  - Next, 0A000002 (BEQ) gives PCWrite=1 in BRANCH.
  - 1A000002 (BNE) gives PCWrite=0, while still taking 3 cycles.
- E1913004 (ORRS) with ALUFlags=1011: N and Z update to 1 and 0, C and V keep their previous values.
- Reset asserted during MEMWR: MemWrite drops to 0 immediately, State=FETCH, Flags=0000.
